// File: rtl/avalon_mem_arbiter.sv
// Two-master / one-slave Avalon arbiter in front of the test RAM, with LATENCY stall cycles per access.
// Build option ARB_DATA_PRIORITY_EN: m1 (data port) wins every tie instead of round-robin.
module avalon_mem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    output logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t     state;
    logic [3:0] counter;
    logic       grant;       // 0 = m0, 1 = m1
    logic       req0, req1, pick;

    assign req0 = m0_read;
    assign req1 = m1_read | m1_write;

`ifdef ARB_DATA_PRIORITY_EN
    assign pick = req1;
`else
    logic last_grant;
    // On a tie, m1 wins only when m0 had the previous transfer.
    assign pick = req1 & (~req0 | ~last_grant);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            counter         <= 4'd0;
            grant           <= 1'b0;
`ifndef ARB_DATA_PRIORITY_EN
            last_grant      <= 1'b1;
`endif
            mem_waitrequest <= 1'b1;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= 32'd0;
            mem_writedata   <= 32'd0;
            mem_byteenable  <= 4'd0;
            m0_waitrequest  <= 1'b1;
            m1_waitrequest  <= 1'b1;
            m0_readdata     <= 32'd0;
            m1_readdata     <= 32'd0;
        end else begin
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant   <= pick;
                        counter <= LAT4;
                        if (pick) begin
                            mem_address    <= m1_address;
                            mem_read       <= m1_read;
                            // read+write together is treated as a plain read
                            mem_write      <= m1_write & ~m1_read;
                            mem_writedata  <= m1_writedata;
                            mem_byteenable <= m1_byteenable;
                        end else begin
                            mem_address    <= m0_address;
                            mem_read       <= 1'b1;
                            mem_write      <= 1'b0;
                            mem_byteenable <= 4'hF;
                        end
                        if (LATENCY == 0) begin
                            state           <= ACCESS;
                            mem_waitrequest <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    counter <= counter - 4'd1;
                    if (counter == 4'd1) begin
                        state           <= ACCESS;
                        mem_waitrequest <= 1'b0;
                    end
                end
                ACCESS: begin
                    state           <= RESP;
                    mem_waitrequest <= 1'b1;
                    mem_read        <= 1'b0;
                    mem_write       <= 1'b0;
                    if (grant) begin
                        m1_waitrequest <= 1'b0;
                        if (mem_read)
                            m1_readdata <= mem_readdata;
                    end else begin
                        m0_waitrequest <= 1'b0;
                        m0_readdata    <= mem_readdata;
                    end
                end
                RESP: begin
                    state <= IDLE;
`ifndef ARB_DATA_PRIORITY_EN
                    last_grant <= grant;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter: directed cases plus random traffic against a transaction-level model.
// A second LATENCY=0 instance checks the zero-stall cadence.
module tb_avalon_mem_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_address, m1_address, m1_writedata, m0_readdata, m1_readdata;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        m0_read, m1_read, m1_write, m0_waitrequest, m1_waitrequest;
    logic        mem_read, mem_write, mem_waitrequest;
    logic [3:0]  m1_byteenable, mem_byteenable;

    avalon_mem_arbiter #(.LATENCY(LAT)) u_dut (
        .clk(clk), .reset(rst),
        .m0_address(m0_address), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
    );

    // zero-latency instance, m0 reading continuously
    logic        z_rst = 1'b1;
    logic        z_m0_waitrequest, z_m1_waitrequest, z_mem_read, z_mem_write, z_mem_waitrequest;
    logic [31:0] z_m0_readdata, z_m1_readdata, z_mem_address, z_mem_writedata, z_mem_readdata;
    logic [3:0]  z_mem_byteenable;

    avalon_mem_arbiter #(.LATENCY(0)) u_dut_z (
        .clk(clk), .reset(z_rst),
        .m0_address(32'h0000_0040), .m0_read(1'b1),
        .m0_waitrequest(z_m0_waitrequest), .m0_readdata(z_m0_readdata),
        .m1_address(32'd0), .m1_read(1'b0), .m1_write(1'b0),
        .m1_writedata(32'd0), .m1_byteenable(4'd0),
        .m1_waitrequest(z_m1_waitrequest), .m1_readdata(z_m1_readdata),
        .mem_address(z_mem_address), .mem_read(z_mem_read), .mem_write(z_mem_write),
        .mem_writedata(z_mem_writedata), .mem_byteenable(z_mem_byteenable),
        .mem_waitrequest(z_mem_waitrequest), .mem_readdata(z_mem_readdata)
    );

    always @(negedge z_mem_waitrequest) z_mem_readdata = z_mem_address ^ 32'hDEAD_BEEF;

    // RAM model: acts on each falling edge of mem_waitrequest
    logic [31:0] ram [0:2047];
    int falls = 0;
    always @(negedge mem_waitrequest) begin
        falls++;
        if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address[12:2]][8*b +: 8] = mem_writedata[8*b +: 8];
        end else if (mem_read) begin
            mem_readdata = ram[mem_address[12:2]];
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // transaction-level reference model
    logic [31:0] ref_mem [0:2047];
    int          cyc = 0, t0 = 0, resp_m = -1, acc_cnt = 0;
    bit          busy = 0, g = 0, last_g = 1, in_acc = 0, strobes = 0, after_rst = 0;
    req_t        cur;
    logic [31:0] val = 0, exp_rd0 = 0, exp_rd1 = 0;

    task automatic model_step();
        logic [10:0] idx;
        cyc++;
        in_acc = 0;
        resp_m = -1;
        after_rst = rst;
        if (rst) begin
            busy = 0; last_g = 1; exp_rd0 = 0; exp_rd1 = 0; strobes = 0;
            return;
        end
        if (!busy) begin
            if (m0_read || m1_read || m1_write) begin
                if (m0_read && (m1_read || m1_write)) begin
`ifdef ARB_DATA_PRIORITY_EN
                    g = 1;
`else
                    g = !last_g;
`endif
                end else begin
                    g = !m0_read;
                end
                cur.addr = g ? m1_address : m0_address;
                cur.rd   = g ? m1_read : 1'b1;
                cur.wr   = g ? (m1_write && !m1_read) : 1'b0;
                cur.wd   = m1_writedata;
                cur.be   = g ? m1_byteenable : 4'hF;
                busy = 1;
                t0 = cyc;
            end
        end else if (cyc == t0 + LAT + 1) begin
            resp_m = g;
            if (!g) exp_rd0 = val;
            else if (cur.rd) exp_rd1 = val;
        end else if (cyc == t0 + LAT + 2) begin
            busy = 0;
            last_g = g;
        end
        if (busy && cyc == t0 + LAT) begin
            in_acc = 1;
            acc_cnt++;
            idx = cur.addr[12:2];
            if (cur.wr) begin
                for (int b = 0; b < 4; b++)
                    if (cur.be[b]) ref_mem[idx][8*b +: 8] = cur.wd[8*b +: 8];
            end else begin
                val = ref_mem[idx];
            end
        end
        strobes = busy && (cyc <= t0 + LAT);
    endtask

    int          obs_g[$];
    logic [31:0] obs_rd0, obs_rd1;
    bit          z_on = 0;
    int          z_k = 0;

    task automatic check_cycle();
        chk("m0_wait", m0_waitrequest, resp_m != 0);
        chk("m1_wait", m1_waitrequest, resp_m != 1);
        chk("mem_wait", mem_waitrequest, !in_acc);
        chk("mem_read", mem_read, strobes && cur.rd);
        chk("mem_write", mem_write, strobes && cur.wr);
        chk("m0_rdata", m0_readdata, exp_rd0);
        chk("m1_rdata", m1_readdata, exp_rd1);
        if (in_acc) begin
            chk("mem_addr", mem_address, cur.addr);
            chk("mem_be", mem_byteenable, cur.be);
            if (cur.wr) chk("mem_wdata", mem_writedata, cur.wd);
        end
        if (after_rst) begin
            chk("rst_addr", mem_address, 32'd0);
            chk("rst_wdata", mem_writedata, 32'd0);
            chk("rst_be", mem_byteenable, 4'd0);
        end
        if (m0_waitrequest === 1'b0) begin obs_g.push_back(0); obs_rd0 = m0_readdata; end
        if (m1_waitrequest === 1'b0) begin obs_g.push_back(1); obs_rd1 = m1_readdata; end
        if (z_on) begin
            chk("z_mem_wait", z_mem_waitrequest, (z_k % 3) != 0);
            chk("z_m0_wait", z_m0_waitrequest, (z_k % 3) != 1);
            if (z_k % 3 == 1) chk("z_rdata", z_m0_readdata, 32'h40 ^ 32'hDEAD_BEEF);
        end
    endtask

    // Avalon masters: hold each request until the edge that ends its response cycle
    req_t q0[$], q1[$];
    bit   act0 = 0, act1 = 0, fin0 = 0, fin1 = 0;

    task automatic drive_masters();
        req_t r;
        if (act0 && resp_m == 0) fin0 = 1;
        else if (fin0) begin act0 = 0; fin0 = 0; end
        if (!act0 && q0.size() > 0) begin
            r = q0.pop_front();
            m0_address = r.addr; m0_read = 1'b1; act0 = 1;
        end
        if (!act0) begin m0_read = 1'b0; m0_address = $urandom(); end
        if (act1 && resp_m == 1) fin1 = 1;
        else if (fin1) begin act1 = 0; fin1 = 0; end
        if (!act1 && q1.size() > 0) begin
            r = q1.pop_front();
            m1_address = r.addr; m1_read = r.rd; m1_write = r.wr;
            m1_writedata = r.wd; m1_byteenable = r.be; act1 = 1;
        end
        if (!act1) begin
            m1_read = 1'b0; m1_write = 1'b0;
            m1_address = $urandom(); m1_writedata = $urandom();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        if (z_on) z_k++;
        @(negedge clk);
        check_cycle();
        drive_masters();
    endtask

    task automatic drop_masters();
        q0.delete(); q1.delete();
        act0 = 0; act1 = 0; fin0 = 0; fin1 = 0;
        m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    task automatic do_reset();
        drop_masters();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || act0 || act1 || q0.size() > 0 || q1.size() > 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", {31'd0, busy || act0 || act1}, 32'd0);
    endtask

    function automatic req_t mk(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wd = wd; r.be = be;
        return r;
    endfunction

    task automatic rand_req(input bit is_m1, output req_t r);
        int k;
        r.addr = $urandom();
        r.addr[12:2] = 11'($urandom_range(0, 15));
        r.addr[1:0] = 2'b00;
        r.wd = $urandom();
        r.be = 4'($urandom_range(1, 15));
        k = $urandom_range(0, 5);
        r.rd = !is_m1 || (k < 3) || (k == 5);
        r.wr = is_m1 && (k >= 3);
    endtask

    initial begin
        req_t r;
        int f0, mis;
        logic [31:0] prior;
        for (int i = 0; i < 2048; i++) begin ram[i] = 32'd0; ref_mem[i] = 32'd0; end
        m0_address = 0; m1_address = 0; m1_writedata = 0; m1_byteenable = 0;
        m0_read = 0; m1_read = 0; m1_write = 0;

        // reset values, and the LATENCY=0 cadence while the main DUT is held
        tick(); tick();
        z_rst = 1'b0;
        z_k = -1;
        z_on = 1;
        for (int i = 0; i < 9; i++) tick();
        z_on = 0;
        rst = 1'b0;

        // instruction fetch from the boot vector
        ram[0] = 32'h3C01_1234; ref_mem[0] = 32'h3C01_1234;
        f0 = falls;
        q0.push_back(mk(1, 0, 32'hBFC0_0000, 0, 4'hF));
        drain();
        chk("boot_rdata", obs_rd0, 32'h3C01_1234);
        chk("boot_falls", falls - f0, 1);

        // byte-enabled write then read back
        q1.push_back(mk(0, 1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101));
        q1.push_back(mk(1, 0, 32'h0000_0010, 0, 4'hF));
        drain();
        chk("be_merge", obs_rd1, 32'h00BB_00DD);

        // read and write together acts as a read
        ram[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        q1.push_back(mk(1, 1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF));
        drain();
        chk("rw_rdata", obs_rd1, 32'h1122_3344);
        chk("rw_ram", ram[4], 32'h1122_3344);

        // simultaneous held requests from reset
        do_reset();
        obs_g.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1, 0, 32'h0000_0100, 0, 4'hF));
            q1.push_back(mk(1, 0, 32'h0000_0104, 0, 4'hF));
        end
        drain();
        chk("tie_count", obs_g.size(), 6);
`ifdef ARB_DATA_PRIORITY_EN
        chk("tie_g0", obs_g[0], 1); chk("tie_g1", obs_g[1], 1); chk("tie_g2", obs_g[2], 1);
`else
        chk("tie_g0", obs_g[0], 0); chk("tie_g1", obs_g[1], 1); chk("tie_g2", obs_g[2], 0);
`endif

        // reset during the stall of an m1 write
        prior = ram[8];
        q1.push_back(mk(0, 1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF));
        tick();
        tick();
        drop_masters();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_ram", ram[8], prior);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 3) == 0) begin rand_req(0, r); q0.push_back(r); end
            if (q1.size() < 2 && $urandom_range(0, 2) == 0) begin rand_req(1, r); q1.push_back(r); end
            tick();
        end
        drain();

        mis = 0;
        for (int i = 0; i < 2048; i++) if (ram[i] !== ref_mem[i]) mis++;
        chk("ram_image", mis, 0);
        chk("access_count", falls, acc_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
